cnn_ctrl: RTL and testbench
===========================

CNN_CTRL -- requirements
Module: cnn_ctrl

Interface
REQ-001 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL provide port: in_valid  input  1  input beat strobe; one beat per cycle, 75 beats per pattern.
REQ-004 SHALL provide port: Opt  input  1  activation option; sampled on beat 0 only.
REQ-005 SHALL provide port: dp_done  input  1  datapath single-cycle pulse: all three results ready.
REQ-006 SHALL provide port: ld_kernel  output  1  kernel register write enable (Kernel_ch1/Kernel_ch2).
REQ-007 SHALL provide port: kernel_idx  output  4  kernel write index, 0..11.
REQ-008 SHALL provide port: ld_weight  output  1  weight register write enable.
REQ-009 SHALL provide port: weight_idx  output  5  weight write index, 0..23.
REQ-010 SHALL provide port: img_we  output  1  image buffer write enable.
REQ-011 SHALL provide port: img_waddr  output  7  image buffer address, 0..74.
REQ-012 SHALL provide port: opt_q  output  1  latched Opt.
REQ-013 SHALL provide port: conv_start  output  1  one-cycle datapath start pulse.
REQ-014 SHALL provide port: res_sel  output  2  result mux select, 0..2.
REQ-015 SHALL provide port: out_valid  output  1  result-valid strobe.
REQ-016 SHALL provide port: busy  output  1  high in any state other than IDLE.
REQ-017 SHALL provide port: timeout  output  1  one-cycle pulse on COMPUTE abort.
REQ-018 SHALL provide port: proto_err  output  1  sticky flag for in_valid outside IDLE/LOAD; cleared only by rst.

Function
REQ-019 SHALL implement states IDLE, LOAD, COMPUTE, OUTPUT, plus a 7-bit beat counter cnt, an 8-bit timer, and a 2-bit output counter.
REQ-020 SHALL assert ld_kernel, ld_weight and img_we combinationally, in the same cycle as the accepted beat, so the datapath captures on that edge.
- img_we = in_valid & (IDLE | LOAD); img_waddr = cnt.
- ld_kernel = img_we & cnt<12; kernel_idx = cnt[3:0].
- ld_weight = img_we & cnt<24; weight_idx = cnt[4:0].
REQ-021 SHALL handle IDLE with in_valid=1 as beat 0: opt_q<=Opt, cnt<=1, next state LOAD; Opt is ignored on every other beat.
REQ-022 SHALL handle LOAD as follows: in_valid=1 increments cnt; in_valid=0 holds cnt and deasserts all enables (gaps allowed, no limit).
REQ-023 SHALL, on accepting beat cnt==74: clear cnt, enter COMPUTE, and raise conv_start for exactly the first COMPUTE cycle (registered).
REQ-024 SHALL count the timer from 0 in COMPUTE.
- dp_done=1: enter OUTPUT; dp_done coinciding with conv_start is accepted.
- Timer reaching 199 without dp_done: pulse timeout, return to IDLE, emit no out_valid.
REQ-025 SHALL ignore dp_done in IDLE, LOAD and OUTPUT.
REQ-026 SHALL drive out_valid=1 (registered) for exactly 3 consecutive cycles in OUTPUT, with res_sel = 0, 1, 2, then return to IDLE.
- dp_done sampled at edge k gives out_valid high in cycles k+1..k+3.
REQ-027 SHALL hold res_sel=0 and out_valid=0 outside OUTPUT, so the downstream out is forced to 0.
REQ-028 SHALL, on in_valid=1 in COMPUTE or OUTPUT: set proto_err, raise no enables, leave state unaffected.
REQ-029 SHALL accept a new beat 0 in the first IDLE cycle after OUTPUT or timeout (back-to-back patterns).
REQ-030 SHALL keep all outputs except opt_q and proto_err free of dependence on previous patterns.

Reset
REQ-031 SHALL, on rst=1 at any time including mid-LOAD/COMPUTE/OUTPUT, immediately force: state IDLE; cnt, timer and output counter 0; all outputs 0 (opt_q=0, proto_err=0).
REQ-032 SHALL make the first beat after rst release beat 0.

Verification
REQ-033 SHALL cover: 75 consecutive beats, Opt=1 on beat 0 -> ld_kernel on beats 0-11, ld_weight on 0-23, img_we on 0-74, opt_q=1, conv_start one cycle after beat 74.
REQ-034 SHALL cover: dp_done 10 cycles after conv_start -> out_valid high exactly 3 cycles, res_sel 0,1,2, then 0/0 and busy=0.
REQ-035 SHALL cover: in_valid dropped for 5 cycles at beat 30 -> img_waddr resumes at 30, conv_start after the 75th accepted beat.
REQ-036 SHALL cover: no dp_done after conv_start -> timeout pulse 200 cycles later, state IDLE, out_valid never high.
REQ-037 SHALL cover: in_valid pulse during OUTPUT -> proto_err=1 and sticky, outputs unchanged; rst asserted mid-LOAD at beat 40 -> all outputs 0 at once, next beat writes img_waddr 0.
REQ-038 SHALL cover: back-to-back patterns, beat 0 in the cycle after the third out_valid -> accepted, opt_q updated.

Source files
------------

// File: rtl/cnn_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cnn_ctrl
// Description : Beat loader and sequencer for a two-channel CNN datapath.
//               Loads 75 beats, starts the convolution and presents 3 results.
// Revision    : 1.0
// ============================================================================
module cnn_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       Opt,
    input  logic       dp_done,
    output logic       ld_kernel,
    output logic [3:0] kernel_idx,
    output logic       ld_weight,
    output logic [4:0] weight_idx,
    output logic       img_we,
    output logic [6:0] img_waddr,
    output logic       opt_q,
    output logic       conv_start,
    output logic [1:0] res_sel,
    output logic       out_valid,
    output logic       busy,
    output logic       timeout,
    output logic       proto_err
);

    localparam logic [6:0] C_LAST_BEAT   = 7'd74;
    localparam logic [6:0] C_NUM_KERNEL  = 7'd12;
    localparam logic [6:0] C_NUM_WEIGHT  = 7'd24;
    localparam logic [7:0] C_TIMER_LIMIT = 8'd199;
    localparam logic [1:0] C_LAST_RES    = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    logic [7:0] timer_q, timer_d;
    logic [1:0] ocnt_q, ocnt_d;
    logic       opt_lat_q, opt_lat_d;
    logic       conv_start_q, conv_start_d;
    logic       out_valid_q, out_valid_d;
    logic [1:0] res_sel_q, res_sel_d;
    logic       timeout_q, timeout_d;
    logic       perr_q, perr_d;
    logic       w_accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            timer_q      <= '0;
            ocnt_q       <= '0;
            opt_lat_q    <= 1'b0;
            conv_start_q <= 1'b0;
            out_valid_q  <= 1'b0;
            res_sel_q    <= '0;
            timeout_q    <= 1'b0;
            perr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            timer_q      <= timer_d;
            ocnt_q       <= ocnt_d;
            opt_lat_q    <= opt_lat_d;
            conv_start_q <= conv_start_d;
            out_valid_q  <= out_valid_d;
            res_sel_q    <= res_sel_d;
            timeout_q    <= timeout_d;
            perr_q       <= perr_d;
        end
    end

    // Enables are gated by rst so every output reads 0 while reset is held.
    assign w_accept = in_valid & ~rst & ((state_q == IDLE) | (state_q == LOAD));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        timer_d      = timer_q;
        ocnt_d       = ocnt_q;
        opt_lat_d    = opt_lat_q;
        conv_start_d = 1'b0;
        out_valid_d  = 1'b0;
        res_sel_d    = 2'd0;
        timeout_d    = 1'b0;
        perr_d       = perr_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opt_lat_d = Opt;
                    cnt_d     = 7'd1;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    if (cnt_q == C_LAST_BEAT) begin
                        cnt_d        = '0;
                        timer_d      = '0;
                        conv_start_d = 1'b1;
                        state_d      = COMPUTE;
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
            end
            COMPUTE: begin
                if (in_valid) perr_d = 1'b1;
                if (dp_done) begin
                    timer_d     = '0;
                    ocnt_d      = '0;
                    out_valid_d = 1'b1;
                    state_d     = OUTPUT;
                end else if (timer_q == C_TIMER_LIMIT) begin
                    timer_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            OUTPUT: begin
                if (in_valid) perr_d = 1'b1;
                // res_sel follows ocnt one step ahead so the select and strobe stay registered.
                if (ocnt_q == C_LAST_RES) begin
                    ocnt_d  = '0;
                    state_d = IDLE;
                end else begin
                    ocnt_d      = ocnt_q + 2'd1;
                    out_valid_d = 1'b1;
                    res_sel_d   = ocnt_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign img_we     = w_accept;
    assign img_waddr  = cnt_q;
    assign ld_kernel  = w_accept & (cnt_q < C_NUM_KERNEL);
    assign kernel_idx = cnt_q[3:0];
    assign ld_weight  = w_accept & (cnt_q < C_NUM_WEIGHT);
    assign weight_idx = cnt_q[4:0];
    assign opt_q      = opt_lat_q;
    assign conv_start = conv_start_q;
    assign out_valid  = out_valid_q;
    assign res_sel    = res_sel_q;
    assign timeout    = timeout_q;
    assign proto_err  = perr_q;
    assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cnn_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnn_ctrl
// Description : Scoreboard bench for cnn_ctrl with randomized pattern traffic.
// Revision    : 1.0
// ============================================================================
module tb_cnn_ctrl;

    logic       clk = 1'b0;
    logic       rst, in_valid, Opt, dp_done;
    logic       ld_kernel, ld_weight, img_we, opt_q, conv_start, out_valid;
    logic       busy, timeout, proto_err;
    logic [3:0] kernel_idx;
    logic [4:0] weight_idx;
    logic [6:0] img_waddr;
    logic [1:0] res_sel;

    cnn_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .Opt(Opt), .dp_done(dp_done),
        .ld_kernel(ld_kernel), .kernel_idx(kernel_idx),
        .ld_weight(ld_weight), .weight_idx(weight_idx),
        .img_we(img_we), .img_waddr(img_waddr), .opt_q(opt_q),
        .conv_start(conv_start), .res_sel(res_sel), .out_valid(out_valid),
        .busy(busy), .timeout(timeout), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event kinds: 0 image write (val = address), 1 conv_start, 2 result (val = sel), 3 timeout
    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    ev_t q[$];
    int  checks   = 0;
    int  failures = 0;
    bit  exp_perr = 1'b0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(int k, int c, int v);
        ev_t e;
        e.kind = k; e.cyc = c; e.val = v;
        q.push_back(e);
    endtask

    task automatic check_ev(int kind, int val);
        ev_t e;
        bit  ok;
        checks++;
        if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: got kind=%0d val=%0d at cycle %0d, expected nothing", kind, val, cyc);
            return;
        end
        e  = q.pop_front();
        ok = (e.kind == kind) && (e.cyc == cyc) && (e.val == val);
        if (kind == 0 && ok) begin
            ok = (ld_kernel == (e.val < 12)) && (ld_weight == (e.val < 24));
            if (e.val < 12 && kernel_idx != 4'(e.val)) ok = 1'b0;
            if (e.val < 24 && weight_idx != 5'(e.val)) ok = 1'b0;
        end
        if (!ok) begin
            failures++;
            $display("FAIL event: got kind=%0d val=%0d cyc=%0d lk=%0b ki=%0d lw=%0b wi=%0d, expected kind=%0d val=%0d cyc=%0d",
                     kind, val, cyc, ld_kernel, kernel_idx, ld_weight, weight_idx, e.kind, e.val, e.cyc);
        end
    endtask

    // Monitor: registered events are checked before the same-cycle image write.
    always @(negedge clk) begin
        if (!rst) begin
            if (conv_start) check_ev(1, 0);
            if (out_valid)  check_ev(2, int'(res_sel));
            if (timeout)    check_ev(3, 0);
            if (img_we)     check_ev(0, int'(img_waddr));
            if (!out_valid && res_sel != 2'd0) begin
                checks++;
                failures++;
                $display("FAIL res_sel_idle: got %0d expected 0 (cycle %0d)", res_sel, cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        Opt      = 1'($urandom);
        dp_done  = 1'($urandom % 4 == 0);
        tick();
    endtask

    task automatic beat(int b, bit opt);
        in_valid = 1'b1;
        Opt      = (b == 0) ? opt : 1'($urandom);
        dp_done  = 1'($urandom % 4 == 0);
        push(0, cyc, b);
        tick();
    endtask

    // d < 0 means the datapath never answers.
    task automatic run_pattern(bit opt, int gap_at, int gap_len, bit rnd_gaps,
                               int d, bit stray_c, bit stray_o);
        int cs;
        for (int b = 0; b < 75; b++) begin
            if (b > 0 && b == gap_at) repeat (gap_len) idle_cycle();
            if (b > 0 && rnd_gaps && ($urandom % 8 == 0)) repeat ($urandom_range(1, 3)) idle_cycle();
            beat(b, opt);
        end
        in_valid = 1'b0;
        dp_done  = 1'b0;
        cs = cyc;
        push(1, cs, 0);
        chk("opt_q_latched", int'(opt_q), int'(opt));
        chk("busy_compute", int'(busy), 1);
        if (d < 0) begin
            push(3, cs + 200, 0);
            for (int i = 0; i < 200; i++) begin
                in_valid = stray_c && ($urandom % 16 == 0);
                if (in_valid) exp_perr = 1'b1;
                dp_done = 1'b0;
                tick();
            end
            in_valid = 1'b0;
            chk("busy_after_timeout", int'(busy), 0);
            chk("timeout_cycle_no_valid", int'(out_valid), 0);
        end else begin
            for (int i = 0; i <= d; i++) begin
                in_valid = stray_c && ($urandom % 16 == 0);
                if (in_valid) exp_perr = 1'b1;
                dp_done = (i == d);
                if (i == d) begin
                    push(2, cyc + 1, 0);
                    push(2, cyc + 2, 1);
                    push(2, cyc + 3, 2);
                end
                tick();
            end
            for (int j = 0; j < 3; j++) begin
                in_valid = stray_o && (j == 1 || ($urandom % 2 == 0));
                if (in_valid) exp_perr = 1'b1;
                dp_done = 1'($urandom);
                tick();
            end
            in_valid = 1'b0;
            dp_done  = 1'b0;
            chk("busy_after_output", int'(busy), 0);
            chk("out_valid_after_output", int'(out_valid), 0);
            chk("res_sel_after_output", int'(res_sel), 0);
        end
        chk("proto_err", int'(proto_err), int'(exp_perr));
    endtask

    function automatic int all_outputs();
        return int'({ld_kernel, kernel_idx, ld_weight, weight_idx, img_we, img_waddr,
                     opt_q, conv_start, res_sel, out_valid, busy, timeout, proto_err});
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; Opt = 1'b0; dp_done = 1'b0;
        tick();
        tick();
        chk("reset_outputs", all_outputs(), 0);
        rst = 1'b0;
        idle_cycle();

        // Straight load with Opt=1, answer 10 cycles after conv_start.
        run_pattern(1'b1, -1, 0, 1'b0, 10, 1'b0, 1'b0);
        idle_cycle();
        // Five-cycle gap at beat 30 and no datapath answer.
        run_pattern(1'b0, 30, 5, 1'b0, -1, 1'b0, 1'b0);
        // Back-to-back after timeout; dp_done coincides with conv_start; stray beat in OUTPUT.
        run_pattern(1'b1, -1, 0, 1'b0, 0, 1'b0, 1'b1);
        // Back-to-back after the third result; latest possible answer.
        run_pattern(1'b0, -1, 0, 1'b1, 199, 1'b1, 1'b0);

        // Reset during LOAD while beat 40 is presented.
        for (int b = 0; b < 40; b++) beat(b, 1'b1);
        in_valid = 1'b1;
        Opt      = 1'b1;
        rst      = 1'b1;
        #1;
        chk("mid_load_reset_outputs", all_outputs(), 0);
        tick();
        in_valid = 1'b0;
        rst      = 1'b0;
        exp_perr = 1'b0;
        #1;
        chk("post_reset_proto_err", int'(proto_err), 0);
        chk("post_reset_opt_q", int'(opt_q), 0);
        run_pattern(1'b1, -1, 0, 1'b1, 5, 1'b0, 1'b0);

        for (int p = 0; p < 5; p++) begin
            if ($urandom % 2 == 0) idle_cycle();
            run_pattern(1'($urandom), -1, 0, 1'b1,
                        ($urandom % 3 == 0) ? -1 : int'($urandom_range(0, 199)),
                        1'($urandom), 1'($urandom));
        end

        repeat (20) idle_cycle();
        chk("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
